// File: rtl/axi_config_regfile.sv
// Config-bus register bank: RW control words, live RO status, W1C interrupt block with mask, and a pulse register.
// Optional AXI_CONFIG_REGFILE_ACCESS_CNT_EN adds a read-only access counter at word index NUM_RW+4.
module axi_config_regfile #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                    NUM_RW     = 8,
    parameter logic [DATA_WIDTH-1:0] CTRL_RESET = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr,
    input  logic [ADDR_WIDTH-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]        wdata,
    input  logic [STRB_WIDTH-1:0]        wstrb,
    input  logic                         rd,
    input  logic [ADDR_WIDTH-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]        rdata,
    output logic                         rvalid,
    output logic [NUM_RW*DATA_WIDTH-1:0] ctrl,
    input  logic [DATA_WIDTH-1:0]        status,
    input  logic [DATA_WIDTH-1:0]        irq_event,
    output logic                         irq,
    output logic [DATA_WIDTH-1:0]        pulse
);

    localparam int OFFS = $clog2(STRB_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] IDX_STATUS     = ADDR_WIDTH'(NUM_RW);
    localparam logic [ADDR_WIDTH-1:0] IDX_IRQ_STATUS = ADDR_WIDTH'(NUM_RW + 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_IRQ_MASK   = ADDR_WIDTH'(NUM_RW + 2);
    localparam logic [ADDR_WIDTH-1:0] IDX_PULSE      = ADDR_WIDTH'(NUM_RW + 3);

    logic [ADDR_WIDTH-1:0] widx;
    logic [ADDR_WIDTH-1:0] ridx;
    logic [DATA_WIDTH-1:0] wmask;

    assign widx = waddr >> OFFS;
    assign ridx = raddr >> OFFS;

    generate
        for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_wmask
            assign wmask[gi*8 +: 8] = {8{wstrb[gi]}};
        end
    endgenerate

    logic [NUM_RW-1:0][DATA_WIDTH-1:0] ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] irq_status_q, irq_status_d;
    logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [DATA_WIDTH-1:0] irq_clr;
    logic                  irq_q, irq_d;
    logic [DATA_WIDTH-1:0] pulse_q, pulse_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rmux;

`ifdef AXI_CONFIG_REGFILE_ACCESS_CNT_EN
    localparam logic [ADDR_WIDTH-1:0] IDX_ACCESS_CNT = ADDR_WIDTH'(NUM_RW + 4);
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;

    // A cycle carrying both a read and a write counts twice.
    always_comb begin
        cnt_d = cnt_q;
        if (wr) begin
            cnt_d = cnt_q + (rd ? DATA_WIDTH'(2) : DATA_WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        for (int k = 0; k < NUM_RW; k++) begin
            ctrl_d[k] = ctrl_q[k];
            if (wr && widx == ADDR_WIDTH'(k)) begin
                ctrl_d[k] = (ctrl_q[k] & ~wmask) | (wdata & wmask);
            end
        end
    end

    // Set wins over clear: the event OR is applied after the W1C mask.
    always_comb begin
        irq_clr = '0;
        if (wr && widx == IDX_IRQ_STATUS) begin
            irq_clr = wdata & wmask;
        end
        irq_status_d = (irq_status_q & ~irq_clr) | irq_event;

        irq_mask_d = irq_mask_q;
        if (wr && widx == IDX_IRQ_MASK) begin
            irq_mask_d = (irq_mask_q & ~wmask) | (wdata & wmask);
        end

        irq_d = |(irq_status_q & irq_mask_q);

        pulse_d = '0;
        if (wr && widx == IDX_PULSE) begin
            pulse_d = wdata & wmask;
        end
    end

    // Read mux sees register state before any same-cycle write.
    always_comb begin
        rmux = '0;
        for (int k = 0; k < NUM_RW; k++) begin
            if (ridx == ADDR_WIDTH'(k)) begin
                rmux = ctrl_q[k];
            end
        end
        if (ridx == IDX_STATUS) begin
            rmux = status;
        end else if (ridx == IDX_IRQ_STATUS) begin
            rmux = irq_status_q;
        end else if (ridx == IDX_IRQ_MASK) begin
            rmux = irq_mask_q;
        end
`ifdef AXI_CONFIG_REGFILE_ACCESS_CNT_EN
        else if (ridx == IDX_ACCESS_CNT) begin
            rmux = cnt_q;
        end
`endif
    end

    always_comb begin
        rvalid_d = rd;
        rdata_d  = rdata_q;
        if (rd) begin
            rdata_d = rmux;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_RW; k++) begin
                ctrl_q[k] <= CTRL_RESET;
            end
            irq_status_q <= '0;
            irq_mask_q   <= '0;
            irq_q        <= 1'b0;
            pulse_q      <= '0;
            rdata_q      <= '0;
            rvalid_q     <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            irq_status_q <= irq_status_d;
            irq_mask_q   <= irq_mask_d;
            irq_q        <= irq_d;
            pulse_q      <= pulse_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    assign ctrl   = ctrl_q;
    assign irq    = irq_q;
    assign pulse  = pulse_q;
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_axi_config_regfile.sv
// Directed bench for axi_config_regfile: vector table for single-cycle accesses, hand sequences for
// interrupts, back-to-back reads, reset mid-read and the optional AXI_CONFIG_REGFILE_ACCESS_CNT_EN counter.
module tb_axi_config_regfile;

    localparam int NUM_RW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 wr;
    logic [31:0]          waddr;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 rd;
    logic [31:0]          raddr;
    logic [31:0]          rdata;
    logic                 rvalid;
    logic [NUM_RW*32-1:0] ctrl;
    logic [31:0]          status;
    logic [31:0]          irq_event;
    logic                 irq;
    logic [31:0]          pulse;

    int n_cmp = 0;
    int n_err = 0;

    axi_config_regfile #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_RW    (NUM_RW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr       (wr),
        .waddr    (waddr),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .rd       (rd),
        .raddr    (raddr),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .ctrl     (ctrl),
        .status   (status),
        .irq_event(irq_event),
        .irq      (irq),
        .pulse    (pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        rd;
        logic [31:0] raddr;
        logic [31:0] status;
        logic [31:0] exp_rdata;
        logic        exp_rvalid;
        logic [31:0] exp_pulse;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic w, logic [31:0] wa, logic [31:0] wd, logic [3:0] ws,
                                logic r, logic [31:0] ra, logic [31:0] st,
                                logic [31:0] er, logic ev, logic [31:0] ep);
        vec_t v;
        v.wr = w; v.waddr = wa; v.wdata = wd; v.wstrb = ws;
        v.rd = r; v.raddr = ra; v.status = st;
        v.exp_rdata = er; v.exp_rvalid = ev; v.exp_pulse = ep;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", name, act, exp);
        end
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled 1 ns after the next edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                          input logic [3:0] ws, input logic r, input logic [31:0] ra);
        wr = w; waddr = wa; wdata = wd; wstrb = ws; rd = r; raddr = ra;
    endtask

    initial begin
        logic [31:0] exp_ctrl;
        rst = 1'b1; status = '0; irq_event = 32'hFFFF_FFFF;
        set_in(0, 0, 0, 0, 0, 0);

        // Reset: outputs idle, irq_event held high must not latch.
        repeat (3) tick;
        check("rst_rvalid", {31'b0, rvalid}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'b0, irq}, 32'h0);
        check("rst_pulse", pulse, 32'h0);
        rst = 1'b0; irq_event = '0;

        for (int i = 0; i < NUM_RW + 4; i++) begin
            vecs.push_back(mk(0, 0, 0, 0, 1, 32'(i * 4), 0, 32'h0, 1, 0));
        end
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(1, 32'h08, 32'hA5A5_A5A5, 4'b0101, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0A, 0, 32'h00A5_00A5, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h20, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, 0));
        vecs.push_back(mk(1, 32'h20, 32'hFFFF_FFFF, 4'hF, 1, 32'h20, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 0));
        vecs.push_back(mk(1, 32'h2C, 32'hF0F0_0003, 4'hF, 0, 0, 0, 32'h0BAD_F00D, 0, 32'hF0F0_0003));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h2C, 0, 32'h0, 1, 0));
        vecs.push_back(mk(1, 32'h2C, 32'h1234_5678, 4'b0011, 0, 0, 0, 32'h0, 0, 32'h0000_5678));
        vecs.push_back(mk(1, 32'h2C, 32'hFFFF_FFFF, 4'b1000, 0, 0, 0, 32'h0, 0, 32'hFF00_0000));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h34, 0, 32'h0, 1, 0));
        vecs.push_back(mk(1, 32'h34, 32'hFFFF_FFFF, 4'hF, 1, 32'h34, 0, 32'h0, 1, 0));
        vecs.push_back(mk(1, 32'h1C, 32'h1122_3344, 4'hF, 1, 32'h1C, 0, 32'h0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h1C, 0, 32'h1122_3344, 1, 0));
        vecs.push_back(mk(1, 32'h1C, 32'hAABB_CCDD, 4'b1000, 1, 32'h1C, 0, 32'h1122_3344, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 32'h1C, 0, 32'hAA22_3344, 1, 0));

        foreach (vecs[i]) begin
            set_in(vecs[i].wr, vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].rd, vecs[i].raddr);
            status = vecs[i].status;
            tick;
            $display("vec %0d: wr=%0b waddr=%02h rd=%0b raddr=%02h -> rvalid=%0b rdata=%08h pulse=%08h",
                     i, vecs[i].wr, vecs[i].waddr, vecs[i].rd, vecs[i].raddr, rvalid, rdata, pulse);
            check($sformatf("vec%0d_rvalid", i), {31'b0, rvalid}, {31'b0, vecs[i].exp_rvalid});
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_pulse", i), pulse, vecs[i].exp_pulse);
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, 32'h0);
        end
        set_in(0, 0, 0, 0, 0, 0); status = '0;

        for (int k = 0; k < NUM_RW; k++) begin
            exp_ctrl = (k == 2) ? 32'h00A5_00A5 : (k == 7) ? 32'hAA22_3344 : 32'h0;
            check($sformatf("ctrl%0d", k), ctrl[k*32 +: 32], exp_ctrl);
        end

        // Interrupt block: set, mask, clear racing a set, full clear, byte-strobed clear.
        irq_event = 32'h11; tick;
        $display("irq: event 0x11 -> irq=%0b", irq);
        irq_event = '0; set_in(1, 32'h28, 32'h1, 4'hF, 0, 0); tick;
        $display("irq: mask=1 -> irq=%0b", irq);
        check("irq_before_mask", {31'b0, irq}, 32'h0);
        set_in(0, 0, 0, 0, 0, 0); tick;
        check("irq_assert", {31'b0, irq}, 32'h1);
        irq_event = 32'h1; set_in(1, 32'h24, 32'h1, 4'hF, 0, 0); tick;
        $display("irq: W1C 0x01 with event -> irq=%0b", irq);
        irq_event = '0; set_in(0, 0, 0, 0, 1, 32'h24); tick;
        check("irq_set_wins_status", rdata, 32'h11);
        check("irq_set_wins_irq", {31'b0, irq}, 32'h1);
        set_in(1, 32'h24, 32'h11, 4'hF, 0, 0); tick;
        $display("irq: W1C 0x11 -> irq=%0b", irq);
        check("irq_hold_after_clr", {31'b0, irq}, 32'h1);
        set_in(0, 0, 0, 0, 1, 32'h24); tick;
        check("irq_status_cleared", rdata, 32'h0);
        check("irq_drop", {31'b0, irq}, 32'h0);
        irq_event = 32'h101; set_in(0, 0, 0, 0, 0, 0); tick;
        irq_event = '0; set_in(1, 32'h24, 32'hFFFF_FFFF, 4'b0001, 0, 0); tick;
        check("irq_reassert", {31'b0, irq}, 32'h1);
        set_in(0, 0, 0, 0, 1, 32'h24); tick;
        $display("irq: strobed W1C -> rdata=%08h irq=%0b", rdata, irq);
        check("irq_strobed_clr", rdata, 32'h100);
        check("irq_masked_off", {31'b0, irq}, 32'h0);
        set_in(0, 0, 0, 0, 1, 32'h28); tick;
        check("irq_mask_read", rdata, 32'h1);

        // Back-to-back reads with a same-cycle write to the register being read.
        set_in(1, 32'h04, 32'hCAFE_0001, 4'hF, 0, 0); tick;
        set_in(0, 0, 0, 0, 1, 32'h00); tick;
        check("b2b0_rvalid", {31'b0, rvalid}, 32'h1);
        check("b2b0_rdata", rdata, 32'h0);
        set_in(1, 32'h04, 32'h5555_AAAA, 4'hF, 1, 32'h04); tick;
        check("b2b1_rvalid", {31'b0, rvalid}, 32'h1);
        check("b2b1_old_value", rdata, 32'hCAFE_0001);
        set_in(0, 0, 0, 0, 1, 32'h08); tick;
        check("b2b2_rvalid", {31'b0, rvalid}, 32'h1);
        check("b2b2_rdata", rdata, 32'h00A5_00A5);
        set_in(0, 0, 0, 0, 1, 32'h0C); tick;
        check("b2b3_rvalid", {31'b0, rvalid}, 32'h1);
        check("b2b3_rdata", rdata, 32'h0);
        set_in(0, 0, 0, 0, 1, 32'h04); tick;
        check("b2b_new_value", rdata, 32'h5555_AAAA);
        set_in(0, 0, 0, 0, 0, 0); tick;
        $display("b2b: idle -> rvalid=%0b rdata=%08h", rvalid, rdata);
        check("idle_rvalid", {31'b0, rvalid}, 32'h0);
        check("idle_rdata_hold", rdata, 32'h5555_AAAA);

        // Reset arriving right behind a read drops the next rvalid.
        set_in(0, 0, 0, 0, 1, 32'h04); tick;
        check("pre_rst_rvalid", {31'b0, rvalid}, 32'h1);
        rst = 1'b1; irq_event = 32'hFFFF_FFFF; tick;
        $display("midread reset -> rvalid=%0b rdata=%08h", rvalid, rdata);
        check("midrst_rvalid", {31'b0, rvalid}, 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        check("midrst_ctrl1", ctrl[32 +: 32], 32'h0);
        rst = 1'b0; irq_event = '0;
        set_in(0, 0, 0, 0, 1, 32'h24); tick;
        check("midrst_irq_status", rdata, 32'h0);
        set_in(0, 0, 0, 0, 1, 32'h28); tick;
        check("midrst_irq_mask", rdata, 32'h0);

        // Access counter: 3 write beats plus one read+write cycle.
        repeat (3) begin
            set_in(1, 32'h00, 32'h1, 4'hF, 0, 0); tick;
        end
        set_in(1, 32'h00, 32'h2, 4'hF, 1, 32'h00); tick;
        set_in(0, 0, 0, 0, 1, 32'h30); tick;
        $display("access_cnt read -> rvalid=%0b rdata=%08h", rvalid, rdata);
        check("cnt_rvalid", {31'b0, rvalid}, 32'h1);
`ifdef AXI_CONFIG_REGFILE_ACCESS_CNT_EN
        check("access_cnt", rdata, 32'd5);
`else
        check("idx12_unmapped", rdata, 32'h0);
`endif
        set_in(0, 0, 0, 0, 0, 0); tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
